wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 3: number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width per master and slave.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width.
REQ-004 SHALL have parameter OUTSTANDING_MAX, default 3: maximum unacknowledged requests in flight (1..7).
REQ-005 SHALL have port wb_clk_i, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port m_wb_cyc_i, input, MASTER_NUM: per-master cycle.
REQ-008 SHALL have port m_wb_stb_i, input, MASTER_NUM: per-master strobe.
REQ-009 SHALL have port m_wb_we_i, input, MASTER_NUM: per-master write enable.
REQ-010 SHALL have port m_wb_adr_i, input, MASTER_NUM*ADDR_WIDTH: packed addresses; master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port m_wb_dat_i, input, MASTER_NUM*DATA_WIDTH: packed write data, same packing.
REQ-012 SHALL have port m_wb_dat_o, output, DATA_WIDTH: read data, broadcast to all masters.
REQ-013 SHALL have port m_wb_ack_o, output, MASTER_NUM: per-master acknowledge.
REQ-014 SHALL have port m_wb_stall_o, output, MASTER_NUM: per-master stall.
REQ-015 SHALL have ports s_wb_cyc_o, s_wb_stb_o, s_wb_we_o (output, 1), s_wb_adr_o (output, ADDR_WIDTH), s_wb_dat_o (output, DATA_WIDTH): slave-side request.
REQ-016 SHALL have ports s_wb_dat_i (input, DATA_WIDTH), s_wb_ack_i, s_wb_stall_i (input, 1): slave-side response.
REQ-017 SHALL have port grant_o, output, MASTER_NUM: registered one-hot current grant, zero when idle.

Function
REQ-018 SHALL implement pipelined Wishbone B4 on both sides; one slave shared by MASTER_NUM masters.
REQ-019 SHALL use two states: IDLE (no grant) and BUSY (one master granted).
REQ-020 IDLE: if any m_wb_cyc_i bit set, SHALL select round-robin starting at index last+1 (wrapping MASTER_NUM-1 -> 0), load grant_o one-hot, enter BUSY next cycle; no request reaches the slave in the decision cycle (1-cycle grant latency).
REQ-021 IDLE: all m_wb_stall_o SHALL be 1, all m_wb_ack_o 0, s_wb_cyc_o and s_wb_stb_o 0.
REQ-022 BUSY: s_wb_cyc_o SHALL equal granted m_wb_cyc_i; s_wb_we_o, s_wb_adr_o, s_wb_dat_o SHALL combinationally mirror granted master's fields.
REQ-023 BUSY: s_wb_stb_o SHALL equal granted m_wb_stb_i AND (outstanding < OUTSTANDING_MAX).
REQ-024 BUSY: granted m_wb_stall_o SHALL equal s_wb_stall_i OR (outstanding == OUTSTANDING_MAX); non-granted stall SHALL be 1.
REQ-025 BUSY: granted m_wb_ack_o SHALL equal s_wb_ack_i; non-granted ack SHALL be 0; m_wb_dat_o SHALL always equal s_wb_dat_i.
REQ-026 Outstanding counter: +1 on s_wb_stb_o AND NOT s_wb_stall_i; -1 on s_wb_ack_i; unchanged when both occur in one cycle; SHALL never exceed OUTSTANDING_MAX or underflow (ack at zero ignored).
REQ-027 BUSY: when granted m_wb_cyc_i is 0, SHALL return to IDLE next cycle, record granted index as last, clear outstanding, clear grant_o; acks arriving afterwards SHALL not be forwarded.
REQ-028 A master dropping cyc with requests outstanding SHALL abort them (slave sees s_wb_cyc_o low); no error reported.
REQ-029 Non-granted masters asserting cyc during BUSY SHALL wait; no preemption.

Reset
REQ-030 When wb_rst_i is 1 at a clock edge: state IDLE, grant_o 0, outstanding 0, last = MASTER_NUM-1 (master 0 wins first arbitration); reset applied mid-BUSY SHALL drop s_wb_cyc_o to 0 the following cycle.
REQ-031 During and after reset until a grant: all m_wb_stall_o 1, m_wb_ack_o 0, s_wb_cyc_o 0, s_wb_stb_o 0.

Verification
REQ-032 Master 1 alone writes 0x300 to adr 0, slave zero-wait -> grant_o=3'b010 one cycle after cyc, s_wb_dat_o=0x300, m_wb_ack_o=3'b010 for one cycle, IDLE after cyc drop.
REQ-033 Masters 0,1,2 hold cyc simultaneously from reset, each does one transfer then drops cyc for one cycle and re-requests -> grant sequence 0,1,2,0.
REQ-034 Master 0 issues 5 back-to-back reads, slave acks 4 cycles after each request, OUTSTANDING_MAX=3 -> stall to master 0 after third accepted request, never more than 3 in flight, 5 acks total.
REQ-035 Slave holds s_wb_stall_i=1 for 3 cycles -> granted stall 1 for those cycles, outstanding unchanged, request accepted on first non-stall cycle.
REQ-036 Master 2 drops cyc with 2 outstanding, slave later acks -> no m_wb_ack_o pulse, next grant starts with outstanding 0.
REQ-037 wb_rst_i asserted one cycle during BUSY -> s_wb_cyc_o 0 next cycle, grant_o 0, next arbitration grants master 0 if requesting.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin arbiter that lets several pipelined Wishbone B4 masters share
// one slave. Only one master is granted at a time, and it keeps the grant
// until it drops cyc. The number of requests in flight is capped so that
// slave acknowledges can always be matched to the granted master.
module wb_arbiter #(
    parameter int MASTER_NUM      = 3,
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int OUTSTANDING_MAX = 3
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic [MASTER_NUM-1:0]            m_wb_cyc_i,
    input  logic [MASTER_NUM-1:0]            m_wb_stb_i,
    input  logic [MASTER_NUM-1:0]            m_wb_we_i,
    input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_wb_adr_i,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_wb_dat_i,
    output logic [DATA_WIDTH-1:0]            m_wb_dat_o,
    output logic [MASTER_NUM-1:0]            m_wb_ack_o,
    output logic [MASTER_NUM-1:0]            m_wb_stall_o,
    output logic                             s_wb_cyc_o,
    output logic                             s_wb_stb_o,
    output logic                             s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]            s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]            s_wb_dat_o,
    input  logic [DATA_WIDTH-1:0]            s_wb_dat_i,
    input  logic                             s_wb_ack_i,
    input  logic                             s_wb_stall_i,
    output logic [MASTER_NUM-1:0]            grant_o
);

    localparam int IDX_W = $clog2(MASTER_NUM);

    localparam logic       ST_IDLE = 1'b0;
    localparam logic       ST_BUSY = 1'b1;

    // The outstanding limit never exceeds 7, so a 3-bit counter always fits.
    localparam logic [2:0] OUT_MAX = 3'(OUTSTANDING_MAX);

    logic             state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_idx;
    logic [2:0]       outstanding;

    logic             any_req;
    logic [IDX_W-1:0] next_idx;
    int               cand;

    logic                  g_cyc;
    logic                  g_stb;
    logic                  g_we;
    logic [ADDR_WIDTH-1:0] g_adr;
    logic [DATA_WIDTH-1:0] g_dat;

    logic busy;
    logic at_limit;
    logic s_accept;
    logic s_retire;

    // Round-robin pick: scan from the master after the last one served,
    // wrapping around, and take the first one holding cyc.
    always_comb begin
        any_req  = 1'b0;
        next_idx = '0;
        cand     = 0;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            cand = (int'(last_idx) + k) % MASTER_NUM;
            if (!any_req && m_wb_cyc_i[cand]) begin
                any_req  = 1'b1;
                next_idx = IDX_W'(cand);
            end
        end
    end

    // Select the granted master's request fields; grant_o is one-hot or zero,
    // so everything reads as zero while idle.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (grant_o[i]) begin
                g_cyc = m_wb_cyc_i[i];
                g_stb = m_wb_stb_i[i];
                g_we  = m_wb_we_i[i];
                g_adr = m_wb_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_dat = m_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy     = (state == ST_BUSY);
    assign at_limit = (outstanding == OUT_MAX);

    assign s_wb_cyc_o = busy & g_cyc;
    assign s_wb_stb_o = busy & g_stb & (outstanding < OUT_MAX);
    assign s_wb_we_o  = g_we;
    assign s_wb_adr_o = g_adr;
    assign s_wb_dat_o = g_dat;

    assign s_accept = s_wb_stb_o & ~s_wb_stall_i;
    assign s_retire = s_wb_ack_i & (outstanding != 3'd0);

    assign m_wb_dat_o = s_wb_dat_i;

    // Route ack and stall back: only the granted master sees the slave,
    // everyone else is held off with stall and never sees an ack.
    always_comb begin
        m_wb_ack_o   = '0;
        m_wb_stall_o = '1;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (busy && grant_o[i]) begin
                m_wb_ack_o[i]   = s_wb_ack_i;
                m_wb_stall_o[i] = s_wb_stall_i | at_limit;
            end
        end
    end

    // Grant state machine and in-flight request counter. Dropping cyc
    // abandons whatever is still in flight, so the counter restarts at zero.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            grant_o     <= '0;
            grant_idx   <= '0;
            last_idx    <= IDX_W'(MASTER_NUM - 1);
            outstanding <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    outstanding <= 3'd0;
                    if (any_req) begin
                        state     <= ST_BUSY;
                        grant_idx <= next_idx;
                        grant_o   <= MASTER_NUM'(1) << next_idx;
                    end
                end
                ST_BUSY: begin
                    if (!g_cyc) begin
                        state       <= ST_IDLE;
                        last_idx    <= grant_idx;
                        grant_o     <= '0;
                        outstanding <= 3'd0;
                    end else if (s_accept && !s_retire) begin
                        outstanding <= outstanding + 3'd1;
                    end else if (s_retire && !s_accept) begin
                        outstanding <= outstanding - 3'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

endmodule
